// File: rtl/led_center_out_seq.sv
// Centre-out LED animation stepped by rising edges of the slow clk_hz toggle.
// clk_hz is synchronised into the clki domain; each rising edge advances the sequence by one step.
module led_center_out_seq #(
  parameter int N_LED      = 8,
  parameter int HOLD_TICKS = 2
) (
  input  logic                             clki,
  input  logic                             rst,
  input  logic                             clk_hz,
  input  logic                             en,
  input  logic                             mode,
  output logic [N_LED-1:0]                 led,
  output logic [$clog2(N_LED/2+1)-1:0]     step,
  output logic                             busy,
  output logic                             seq_done
);

  localparam int C   = N_LED / 2;
  localparam int K_W = $clog2(C + 1);
  localparam logic [K_W-1:0] K_MAX     = K_W'(C);
  localparam logic [7:0]     HOLD_LAST = 8'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  typedef enum logic [1:0] {IDLE, EXPAND, HOLD, CLEAR} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [K_W-1:0]   k_q;
  logic [7:0]       hcnt_q;
  logic             mode_q;
  logic [N_LED-1:0] led_q;
  logic [K_W-1:0]   step_q;
  logic             busy_q;
  logic             seq_done_q;
  logic             tick;

  // s1 is the metastability-catching stage; the edge is detected between s2 and s3.
  assign tick = s2_q & ~s3_q;

  function automatic logic [N_LED-1:0] pattern(input logic [K_W-1:0] k, input logic dot);
    logic [N_LED-1:0] p;
    int lo, hi;
    p  = '0;
    lo = C - int'(k);
    hi = C - 1 + int'(k);
    for (int i = 0; i < N_LED; i++) begin
      if (dot) p[i] = (i == lo) || (i == hi);
      else     p[i] = (i >= lo) && (i <= hi);
    end
    return p;
  endfunction

  always_ff @(posedge clki) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= IDLE;
      k_q        <= '0;
      hcnt_q     <= '0;
      mode_q     <= 1'b0;
      led_q      <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      s1_q       <= clk_hz;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      seq_done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (en) begin
              state_q <= EXPAND;
              k_q     <= K_W'(1);
              mode_q  <= mode;
              led_q   <= pattern(K_W'(1), mode);
              step_q  <= K_W'(1);
              busy_q  <= 1'b1;
            end
          end
          EXPAND: begin
            if (k_q < K_MAX) begin
              k_q    <= k_q + K_W'(1);
              led_q  <= pattern(k_q + K_W'(1), mode_q);
              step_q <= k_q + K_W'(1);
            end else if (HOLD_TICKS > 0) begin
              state_q <= HOLD;
              hcnt_q  <= '0;
            end else begin
              state_q <= CLEAR;
              led_q   <= '0;
              step_q  <= '0;
            end
          end
          HOLD: begin
            if (hcnt_q == HOLD_LAST) begin
              state_q <= CLEAR;
              led_q   <= '0;
              step_q  <= '0;
            end else begin
              hcnt_q <= hcnt_q + 8'd1;
            end
          end
          CLEAR: begin
            seq_done_q <= 1'b1;
            if (en) begin
              state_q <= EXPAND;
              k_q     <= K_W'(1);
              mode_q  <= mode;
              led_q   <= pattern(K_W'(1), mode);
              step_q  <= K_W'(1);
            end else begin
              state_q <= IDLE;
              k_q     <= '0;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign led      = led_q;
  assign step     = step_q;
  assign busy     = busy_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_led_center_out_seq.sv
// Bench for led_center_out_seq: two instances (hold of 2 and of 0) share stimulus;
// a sequence-position model predicts each step, a monitor pops and compares after the sync latency.
module tb_led_center_out_seq;

  localparam int N_LED = 8;
  localparam int C     = N_LED / 2;
  localparam int SW    = $clog2(C + 1);
  localparam int W     = N_LED + SW + 2;
  localparam int H0    = 2;
  localparam int H1    = 0;

  logic clki = 1'b0;
  logic rst, clk_hz, en, mode;
  logic [N_LED-1:0] led0, led1;
  logic [SW-1:0]    step0, step1;
  logic             busy0, busy1, sd0, sd1;
  logic [W-1:0]     obs0, obs1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int  pos[2];
  bit  mode_l[2];
  int  n_checks = 0;
  int  n_pass   = 0;
  event tick_ev;

  // clock/reset block
  always #5 clki = ~clki;

  led_center_out_seq #(.N_LED(N_LED), .HOLD_TICKS(H0)) u_dut0 (
    .clki(clki), .rst(rst), .clk_hz(clk_hz), .en(en), .mode(mode),
    .led(led0), .step(step0), .busy(busy0), .seq_done(sd0)
  );

  led_center_out_seq #(.N_LED(N_LED), .HOLD_TICKS(H1)) u_dut1 (
    .clki(clki), .rst(rst), .clk_hz(clk_hz), .en(en), .mode(mode),
    .led(led1), .step(step1), .busy(busy1), .seq_done(sd1)
  );

  assign obs0 = {led0, step0, busy0, sd0};
  assign obs1 = {led1, step1, busy1, sd1};

  // reference model: a sequence is just a position counter 0..C+H+1
  function automatic int hold_of(input int d);
    return (d == 0) ? H0 : H1;
  endfunction

  function automatic logic [N_LED-1:0] pat(input int k, input bit dot);
    longint m;
    if (dot) m = (64'd1 << (C - k)) | (64'd1 << (C - 1 + k));
    else     m = ((64'd1 << (2 * k)) - 64'd1) << (C - k);
    return N_LED'(m);
  endfunction

  function automatic logic [W-1:0] model_out(input int d, input logic sd);
    int p;
    logic [N_LED-1:0] l;
    int s;
    p = pos[d];
    if (p == 0 || p == C + hold_of(d) + 1) begin
      l = '0; s = 0;
    end else if (p <= C) begin
      l = pat(p, mode_l[d]); s = p;
    end else begin
      l = pat(C, mode_l[d]); s = C;
    end
    return {l, SW'(s), (p != 0), sd};
  endfunction

  function automatic logic [W-1:0] get_obs(input int d);
    return (d == 0) ? obs0 : obs1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic sd;
      sd = 1'b0;
      if (pos[d] == 0) begin
        if (en) begin pos[d] = 1; mode_l[d] = mode; end
      end else if (pos[d] == C + hold_of(d) + 1) begin
        sd = 1'b1;
        if (en) begin pos[d] = 1; mode_l[d] = mode; end
        else pos[d] = 0;
      end else begin
        pos[d] = pos[d] + 1;
      end
      if (d == 0) exp_q0.push_back(model_out(0, sd));
      else        exp_q1.push_back(model_out(1, sd));
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (led,step,busy,seq_done) at %0t", name, got, exp, $time);
  endtask

  task automatic check_steady(input string name);
    check({name, "_d0"}, obs0, model_out(0, 1'b0));
    check({name, "_d1"}, obs1, model_out(1, 1'b0));
  endtask

  // driver: one clk_hz rising edge, held hi_c cycles then low lo_c cycles
  task automatic do_tick(input int hi_c, input int lo_c);
    model_step();
    @(negedge clki);
    clk_hz = 1'b1;
    -> tick_ev;
    repeat (hi_c) @(negedge clki);
    clk_hz = 1'b0;
    repeat (lo_c) @(negedge clki);
    check_steady("steady");
  endtask

  // monitor: rising edge sampled at E, outputs must change exactly at E+2
  initial begin
    logic [W-1:0] e [2];
    forever begin
      @(tick_ev);
      repeat (3) @(posedge clki);
      #1;
      for (int d = 0; d < 2; d++) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          n_checks++;
          $display("FAIL scoreboard_empty: dut %0d got no expected entry", d);
          e[d] = get_obs(d);
        end else begin
          e[d] = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("step_d%0d", d), get_obs(d), e[d]);
        end
      end
      @(posedge clki);
      #1;
      check("pulse_end_d0", obs0, {e[0][W-1:1], 1'b0});
      check("pulse_end_d1", obs1, {e[1][W-1:1], 1'b0});
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int guard;
    rst = 1'b1; clk_hz = 1'b0; en = 1'b0; mode = 1'b0;
    pos = '{0, 0}; mode_l = '{0, 0};

    // reset held while clk_hz toggles: everything stays zero
    for (int i = 0; i < 5; i++) begin
      @(negedge clki);
      check_steady("reset");
      clk_hz = ~clk_hz;
    end

    // release with clk_hz high gives exactly one tick, even held for 100 cycles
    @(negedge clki);
    clk_hz = 1'b1; en = 1'b1; mode = 1'b0;
    rst = 1'b0;
    model_step();
    -> tick_ev;
    repeat (100) @(negedge clki);
    check_steady("held_high");
    clk_hz = 1'b0;
    repeat (10) @(negedge clki);
    check_steady("falling_edge");

    // fill sequence through hold, clear and restart
    for (int i = 0; i < 7; i++) do_tick(10, 10);

    // dot mode latched at the next start; mode toggled mid-expansion is ignored
    mode = 1'b1;
    for (int i = 0; i < 7; i++) do_tick(10, 10);
    for (int i = 0; i < 4; i++) begin
      mode = ~mode;
      do_tick(3, 7);
    end
    mode = 1'b1;

    // en dropped mid-sequence: sequence finishes, then idle; more ticks change nothing
    do_tick(10, 10);
    en = 1'b0;
    for (int i = 0; i < 12; i++) do_tick(1, 9);

    // reset while the hold-2 instance is in HOLD
    en = 1'b1; mode = 1'b0;
    guard = 0;
    while (pos[0] != C + 1 && guard < 20) begin
      do_tick(5, 5);
      guard++;
    end
    n_checks++;
    if (pos[0] == C + 1) n_pass++;
    else $display("FAIL reach_hold: model position %0d, required %0d", pos[0], C + 1);
    @(negedge clki);
    rst = 1'b1;
    pos = '{0, 0}; mode_l = '{0, 0};
    @(negedge clki);
    check_steady("reset_in_hold");
    rst = 1'b0;
    repeat (5) @(negedge clki);
    check_steady("after_reset");

    // randomized run
    for (int i = 0; i < 60; i++) begin
      en   = ($urandom_range(0, 4) != 0);
      mode = 1'($urandom_range(0, 1));
      do_tick($urandom_range(1, 20), $urandom_range(6, 20));
    end

    repeat (10) @(negedge clki);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
